// File: rtl/pea_result_drain.sv
// pea_result_drain
//   Downstream drain for the PEA result/status output FIFOs. Each frame pops
//   one result/status pair and sends it on a 16-bit valid/ready stream. The
//   first word of a frame is a header that carries an 8-bit sequence number.
//   The block also counts delivered frames. It raises a sticky flag when the
//   two FIFO populations disagree.
//
//   Frame layout:
//     default build : HDR {seq, status[7:0]}, RHI result[31:16], RLO result[15:0]
//     PEA_DRAIN_FULL_STATUS_EN defined : adds SHI status[31:16] and SLO status[15:0].
//     out_last then moves from RLO to SLO.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   enable              drain permission, looked at only while idle
//   result_pop/status_pop  FIFO populations
//   result_data/status_data FIFO read data (valid the cycle after rd_en)
//   rd_en_result/rd_en_status  one-cycle pop strobes, always paired
//   out_data/out_valid/out_ready/out_last  host stream
//   frame_count         frames fully delivered (wraps)
//   busy                high whenever a frame is in flight
//   err_mismatch        sticky result/status population mismatch
module pea_result_drain #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16,
  parameter int POP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [POP_WIDTH-1:0] result_pop,
  input  logic [POP_WIDTH-1:0] status_pop,
  input  logic [WIDTH-1:0]     result_data,
  input  logic [WIDTH-1:0]     status_data,
  output logic                 rd_en_result,
  output logic                 rd_en_status,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          frame_count,
  output logic                 busy,
  output logic                 err_mismatch
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_CAPTURE, S_HDR, S_RHI, S_RLO, S_SHI, S_SLO
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rd_en;
  logic [31:0] r_res;
  logic [7:0]  r_seq;
  logic [15:0] r_frames;
  logic        r_err;
  logic        w_fire;
  logic        w_last;

`ifdef PEA_DRAIN_FULL_STATUS_EN
  logic [31:0] r_sts;
`else
  // Only the low status byte travels in the short frame.
  logic [7:0]  r_sts;
  logic        w_unused_status;
  assign w_unused_status = ^status_data[WIDTH-1:8];
`endif

  // State register plus the datapath registers that follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rd_en  <= 1'b0;
      r_res    <= '0;
      r_sts    <= '0;
      r_seq    <= '0;
      r_frames <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered strobe, high for exactly the POP cycle.
      r_rd_en <= (w_next == S_POP);
      if (r_state == S_CAPTURE) begin
        r_res <= result_data[31:0];
`ifdef PEA_DRAIN_FULL_STATUS_EN
        r_sts <= status_data[31:0];
`else
        r_sts <= status_data[7:0];
`endif
      end
      if (w_fire && w_last) begin
        r_frames <= r_frames + 16'd1;
        r_seq    <= r_seq + 8'd1;
      end
      if (r_state == S_IDLE && result_pop != status_pop)
        r_err <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable && result_pop != '0 && status_pop != '0) w_next = S_POP;
      S_POP:     w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HDR;
      S_HDR:     if (out_ready) w_next = S_RHI;
      S_RHI:     if (out_ready) w_next = S_RLO;
`ifdef PEA_DRAIN_FULL_STATUS_EN
      S_RLO:     if (out_ready) w_next = S_SHI;
      S_SHI:     if (out_ready) w_next = S_SLO;
      S_SLO:     if (out_ready) w_next = S_IDLE;
`else
      S_RLO:     if (out_ready) w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode; words come straight from the state and latched pair,
  // so they hold steady under backpressure.
  always_comb begin
    out_valid = 1'b0;
    w_last    = 1'b0;
    out_data  = '0;
    case (r_state)
      S_HDR: begin out_valid = 1'b1; out_data = {r_seq, r_sts[7:0]}; end
      S_RHI: begin out_valid = 1'b1; out_data = r_res[31:16]; end
`ifdef PEA_DRAIN_FULL_STATUS_EN
      S_RLO: begin out_valid = 1'b1; out_data = r_res[15:0]; end
      S_SHI: begin out_valid = 1'b1; out_data = r_sts[31:16]; end
      S_SLO: begin out_valid = 1'b1; out_data = r_sts[15:0]; w_last = 1'b1; end
`else
      S_RLO: begin out_valid = 1'b1; out_data = r_res[15:0]; w_last = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign w_fire       = out_valid && out_ready;
  assign out_last     = w_last;
  assign rd_en_result = r_rd_en;
  assign rd_en_status = r_rd_en;
  assign frame_count  = r_frames;
  assign busy         = (r_state != S_IDLE);
  assign err_mismatch = r_err;

endmodule

// File: tb/tb_pea_result_drain.sv
module tb_pea_result_drain;

`ifdef PEA_DRAIN_FULL_STATUS_EN
  localparam int FRAME_CYC = 8;
`else
  localparam int FRAME_CYC = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [4:0]  result_pop, status_pop;
  logic [31:0] result_data, status_data;
  logic        rd_en_result, rd_en_status;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] frame_count;
  logic        busy, err_mismatch;

  always #5 clk = ~clk;

  pea_result_drain dut (
    .clk(clk), .rst(rst), .enable(enable),
    .result_pop(result_pop), .status_pop(status_pop),
    .result_data(result_data), .status_data(status_data),
    .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_count(frame_count), .busy(busy),
    .err_mismatch(err_mismatch)
  );

  // FIFO model contents and expected-word scoreboard {is_hdr, last, data}.
  logic [31:0] rq[$];
  logic [31:0] sq[$];
  logic [17:0] eq[$];
  int          hdr_cyc[$];
  int total = 0, bad = 0;
  int cyc = 0, seq_m = 0, frames_m = 0, rd_pulses = 0, rd_cyc = 0;
  int extra_words = 0, pop_empty = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_pops();
    result_pop = 5'(rq.size());
    status_pop = 5'(sq.size());
  endtask

  task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
    rq.push_back(r);
    sq.push_back(s);
    update_pops();
  endtask

  task automatic push_result(input logic [31:0] r);
    rq.push_back(r);
    update_pops();
  endtask

  // One clock: observe at the falling edge, apply FIFO effects after the rise.
  task automatic step();
    logic        do_pop;
    logic [17:0] e;
    logic [31:0] pr, ps;
    do_pop = 1'b0;
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(prev_data));
      chk("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (rd_en_result || rd_en_status) begin
      chk("rd_en_pair", 32'(rd_en_status), 32'(rd_en_result));
      rd_pulses++;
      rd_cyc = cyc;
      do_pop = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (eq.size() == 0) extra_words++;
      else begin
        e = eq.pop_front();
        chk("word_data", 32'(out_data), 32'(e[15:0]));
        chk("word_last", 32'(out_last), 32'(e[16]));
        if (e[17]) hdr_cyc.push_back(cyc);
        if (e[16]) begin
          frames_m++;
          seq_m = (seq_m + 1) % 256;
        end
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
    @(posedge clk);
    #1;
    if (do_pop) begin
      if (rq.size() == 0 || sq.size() == 0) pop_empty++;
      else begin
        pr = rq.pop_front();
        ps = sq.pop_front();
        result_data = pr;
        status_data = ps;
        eq.push_back({2'b10, 8'(seq_m), ps[7:0]});
        eq.push_back({2'b00, pr[31:16]});
`ifdef PEA_DRAIN_FULL_STATUS_EN
        eq.push_back({2'b00, pr[15:0]});
        eq.push_back({2'b00, ps[31:16]});
        eq.push_back({2'b01, ps[15:0]});
`else
        eq.push_back({2'b01, pr[15:0]});
`endif
      end
    end
    update_pops();
  endtask

  function automatic bit done();
    return eq.size() == 0 && !busy && (rq.size() == 0 || sq.size() == 0 || !enable);
  endfunction

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (!done() && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset(input bit flush);
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_rden", 32'({rd_en_result, rd_en_status}), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_mismatch), 32'd0);
    eq.delete();
    seq_m = 0;
    frames_m = 0;
    prev_hold = 1'b0;
    if (flush) begin
      rq.delete();
      sq.delete();
    end
    update_pops();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, h0, p0, g;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b1;
    result_data = '0; status_data = '0;
    update_pops();
    repeat (3) @(negedge clk);
    do_reset(1'b1);

    // Idle with empty FIFOs.
    enable = 1'b1;
    repeat (5) step();
    chk("idle_rden", 32'(rd_pulses), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err_mismatch), 32'd0);

    // Single frame.
    push_pair(32'h12345678, 32'h00000003);
    run("single_timeout", 40);
    chk("single_rden", 32'(rd_pulses), 32'd1);
    chk("single_count", 32'(frame_count), 32'd1);
    chk("single_hdrs", 32'(hdr_cyc.size()), 32'd1);
    if (hdr_cyc.size() == 1) chk("single_latency", 32'(hdr_cyc[0] - rd_cyc), 32'd2);

    // Backpressure: hold every word for 4 cycles.
    push_pair(32'h12345678, 32'h00000003);
    g = 0;
    while (!done() && g < 200) begin
      if (out_valid) begin
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
      step();
      g++;
    end
    chk("bp_timeout", 32'(g < 200), 32'd1);
    chk("bp_rden", 32'(rd_pulses), 32'd2);
    chk("bp_count", 32'(frame_count), 32'(frames_m));

    // Three queued pairs back to back.
    hdr_cyc.delete();
    push_pair(32'hA0A1A2A3, 32'h000000B0);
    push_pair(32'hC0C1C2C3, 32'h000000B1);
    push_pair(32'hE0E1E2E3, 32'h000000B2);
    run("three_timeout", 100);
    chk("three_hdrs", 32'(hdr_cyc.size()), 32'd3);
    for (int i = 1; i < hdr_cyc.size(); i++)
      chk("three_spacing", 32'(hdr_cyc[i] - hdr_cyc[i-1]), 32'(FRAME_CYC));
    chk("three_count", 32'(frame_count), 32'd5);
    chk("three_rden", 32'(rd_pulses), 32'd5);

    // Population mismatch: 2 results, 1 status.
    push_pair(32'hCAFEBABE, 32'h5A5A00C3);
    push_result(32'hAAAA5555);
    step();
    chk("mm_err_set", 32'(err_mismatch), 32'd1);
    run("mm_timeout", 40);
    p0 = rd_pulses;
    repeat (6) step();
    chk("mm_rden", 32'(rd_pulses), 32'd6);
    chk("mm_stays_idle", 32'(rd_pulses), 32'(p0));
    chk("mm_err_sticky", 32'(err_mismatch), 32'd1);
    chk("mm_count", 32'(frame_count), 32'd6);

    // Reset mid-frame during RHI.
    do_reset(1'b1);
    push_pair(32'h11112222, 32'h00000044);
    push_pair(32'h33334444, 32'h00000055);
    h0 = hdr_cyc.size();
    g = 0;
    while (hdr_cyc.size() == h0 && g < 40) begin
      step();
      g++;
    end
    chk("mid_reach_rhi", 32'(g < 40), 32'd1);
    chk("mid_valid_pre", 32'(out_valid), 32'd1);
    do_reset(1'b0);
    n0 = rd_pulses;
    run("mid_timeout", 40);
    chk("mid_rden", 32'(rd_pulses - n0), 32'd1);
    chk("mid_count", 32'(frame_count), 32'd1);
    chk("mid_frames", 32'(frames_m), 32'd1);

    chk("extra_words", 32'(extra_words), 32'd0);
    chk("pop_empty", 32'(pop_empty), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
